// File: rtl/span_interp_seq_if.sv
// Span sequencer bus: descriptor input stream, pixel output stream and busy.
//   span_*  : descriptor offered by the master, accepted by the sequencer
//   pix_*   : pixel stream produced by the sequencer, pix_ready from master
//   busy    : sequencer is emitting a span
// master = span producer / pixel consumer, slave = the sequencer itself.
interface span_interp_seq_if #(
  parameter int WIDTH = 32,
  parameter int GUARD = 8,
  parameter int LEN_W = 12
);
  logic                     span_valid;
  logic                     span_ready;
  logic [LEN_W-1:0]         span_x;
  logic [LEN_W-1:0]         span_len;
  logic [WIDTH-1:0]         span_init;
  logic [WIDTH+GUARD-1:0]   span_grad;
  logic                     pix_valid;
  logic                     pix_ready;
  logic [LEN_W-1:0]         pix_x;
  logic [WIDTH-1:0]         pix_val;
  logic                     pix_sat;
  logic                     pix_last;
  logic                     busy;

  modport master (
    output span_valid, span_x, span_len, span_init, span_grad, pix_ready,
    input  span_ready, pix_valid, pix_x, pix_val, pix_sat, pix_last, busy
  );

  modport slave (
    input  span_valid, span_x, span_len, span_init, span_grad, pix_ready,
    output span_ready, pix_valid, pix_x, pix_val, pix_sat, pix_last, busy
  );
endinterface

// File: rtl/span_interp_seq.sv
// Span-level interpolation sequencer.
// Accepts one span descriptor (x, len, init, gradient) in IDLE, then steps a
// guard-bit accumulator once per accepted pixel, emitting rounded, saturated
// WIDTH-bit values with their x coordinate on a valid/ready stream.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - span_interp_seq_if.slave (descriptor in, pixel out, busy)
module span_interp_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int GUARD = 8,
  parameter int LEN_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  span_interp_seq_if.slave  bus
);

  if (GUARD < 1 || FRAC >= WIDTH) begin : g_param_check
    $error("span_interp_seq: GUARD must be >= 1 and FRAC < WIDTH");
  end

  // Accumulator carries one headroom bit above the sign-extended init<<GUARD.
  localparam int ACC_W = WIDTH + GUARD + 1;

  localparam logic [ACC_W-1:0]        ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0]        ACC_MIN = ~ACC_MAX;
  localparam logic [ACC_W-1:0]        HALF    = ACC_W'(1) << (GUARD - 1);
  localparam logic signed [ACC_W-1:0] VMAX    = $signed((ACC_W'(1) << (WIDTH - 1)) - ACC_W'(1));
  localparam logic signed [ACC_W-1:0] VMIN    = ~VMAX;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [ACC_W-1:0]       acc;
  logic [WIDTH+GUARD-1:0] grad_r;
  logic [LEN_W-1:0]       x;
  logic [LEN_W-1:0]       rem;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? ACC_MIN : ACC_MAX;
    return s[ACC_W-1:0];
  endfunction

  // Output rounding: saturating add of one half LSB, arithmetic shift out the
  // guard bits, then clamp into the signed WIDTH-bit range.
  logic [ACC_W-1:0]        acc_h;
  logic signed [ACC_W-1:0] t;
  logic [WIDTH-1:0]        val_c;
  logic                    sat_c;

  always_comb begin
    acc_h = sat_add(acc, HALF);
    t     = $signed(acc_h) >>> GUARD;
    sat_c = 1'b0;
    val_c = t[WIDTH-1:0];
    if (t > VMAX) begin
      val_c = {1'b0, {(WIDTH-1){1'b1}}};
      sat_c = 1'b1;
    end else if (t < VMIN) begin
      val_c = {1'b1, {(WIDTH-1){1'b0}}};
      sat_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      grad_r <= '0;
      x      <= '0;
      rem    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Zero-length descriptors are consumed without leaving IDLE.
          if (bus.span_valid && bus.span_len != '0) begin
            acc    <= {bus.span_init[WIDTH-1], bus.span_init, {GUARD{1'b0}}};
            grad_r <= bus.span_grad;
            x      <= bus.span_x;
            rem    <= bus.span_len;
            state  <= RUN;
          end
        end
        RUN: begin
          if (bus.pix_ready) begin
            if (rem == LEN_W'(1)) begin
              state <= IDLE;
            end else begin
              acc <= sat_add(acc, {grad_r[WIDTH+GUARD-1], grad_r});
              x   <= x + LEN_W'(1);
              rem <= rem - LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs derive from registered state only; pixel fields read zero in IDLE.
  logic run;
  assign run            = (state == RUN);
  assign bus.span_ready = ~run;
  assign bus.busy       = run;
  assign bus.pix_valid  = run;
  assign bus.pix_x      = run ? x : '0;
  assign bus.pix_val    = run ? val_c : '0;
  assign bus.pix_sat    = run & sat_c;
  assign bus.pix_last   = run & (rem == LEN_W'(1));

endmodule

// File: tb/tb_span_interp_seq.sv
// Directed bench for span_interp_seq: a table of spans with hand-computed
// pixel values, plus hand-written backpressure, zero-length, busy-rejection
// and mid-span reset sequences. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_span_interp_seq;
  localparam int WIDTH = 32;
  localparam int FRAC  = 16;
  localparam int GUARD = 8;
  localparam int LEN_W = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  span_interp_seq_if #(.WIDTH(WIDTH), .GUARD(GUARD), .LEN_W(LEN_W)) bus ();

  span_interp_seq #(.WIDTH(WIDTH), .FRAC(FRAC), .GUARD(GUARD), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int hs    = 0;

  always @(posedge clk)
    if (!rst && bus.pix_valid && bus.pix_ready) hs++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [11:0]      x;
    logic [11:0]      len;
    logic [31:0]      init;
    logic [39:0]      grad;
    logic [3:0][31:0] ev;
    logic [3:0]       es;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic offer(input logic [11:0] x, input logic [11:0] len,
                       input logic [31:0] init, input logic [39:0] grad);
    int n = 0;
    bus.span_valid = 1'b1;
    bus.span_x     = x;
    bus.span_len   = len;
    bus.span_init  = init;
    bus.span_grad  = grad;
    while (!bus.span_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_budget", 64'(bus.span_ready), 64'd1);
    @(negedge clk);
    bus.span_valid = 1'b0;
  endtask

  // Check the presented pixel, then let it handshake (pix_ready assumed 1).
  task automatic pix(input string name, input logic [11:0] ex, input logic [31:0] ev,
                     input logic es, input logic el);
    chk({name, "_valid"}, 64'(bus.pix_valid), 64'd1);
    chk({name, "_x"},     64'(bus.pix_x),     64'(ex));
    chk({name, "_val"},   64'(bus.pix_val),   64'(ev));
    chk({name, "_sat"},   64'(bus.pix_sat),   64'(es));
    chk({name, "_last"},  64'(bus.pix_last),  64'(el));
    chk({name, "_sready"}, 64'(bus.span_ready), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int h0;
    offer(v.x, v.len, v.init, v.grad);
    h0 = hs;
    for (int i = 0; i < int'(v.len); i++) begin
      logic [11:0] ex;
      ex = v.x + 12'(i);
      pix($sformatf("v%0d_p%0d", idx, i), ex, v.ev[i], v.es[i], i == int'(v.len) - 1);
    end
    chk($sformatf("v%0d_end_valid", idx), 64'(bus.pix_valid), 64'd0);
    chk($sformatf("v%0d_end_sready", idx), 64'(bus.span_ready), 64'd1);
    chk($sformatf("v%0d_hs", idx), 64'(hs - h0), 64'(v.len));
  endtask

  vec_t tbl[5];

  initial begin
    int h0;
    tbl[0] = '{x: 12'd10, len: 12'd4, init: 32'h0001_0000, grad: 40'h00_0100_0000,
               ev: {32'h4_0000, 32'h3_0000, 32'h2_0000, 32'h1_0000}, es: 4'b0000};
    tbl[1] = '{x: 12'd0, len: 12'd4, init: 32'h0, grad: 40'h00_0000_0080,
               ev: {32'd2, 32'd1, 32'd1, 32'd0}, es: 4'b0000};
    tbl[2] = '{x: 12'd0, len: 12'd4, init: 32'h0, grad: 40'hFF_FFFF_FF80,
               ev: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0}, es: 4'b0000};
    tbl[3] = '{x: 12'd20, len: 12'd3, init: 32'h7FFF_0000, grad: 40'h00_0100_0000,
               ev: {32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_0000}, es: 4'b0110};
    tbl[4] = '{x: 12'd4094, len: 12'd3, init: 32'h0003_0000, grad: 40'h0,
               ev: {32'h0, 32'h3_0000, 32'h3_0000, 32'h3_0000}, es: 4'b0000};

    rst = 1'b1;
    bus.span_valid = 1'b0;
    bus.span_x = '0;
    bus.span_len = '0;
    bus.span_init = '0;
    bus.span_grad = '0;
    bus.pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(bus.pix_valid), 64'd0);
    chk("rst_sready", 64'(bus.span_ready), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_x", 64'(bus.pix_x), 64'd0);
    chk("rst_val", 64'(bus.pix_val), 64'd0);
    chk("rst_sat_last", 64'({bus.pix_sat, bus.pix_last}), 64'd0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i], i);

    // Backpressure on pixel 2 of the basic span.
    offer(12'd10, 12'd4, 32'h0001_0000, 40'h00_0100_0000);
    h0 = hs;
    pix("bp_p0", 12'd10, 32'h1_0000, 1'b0, 1'b0);
    bus.pix_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp_hold%0d_val", c), 64'(bus.pix_val), 64'h2_0000);
      chk($sformatf("bp_hold%0d_x", c), 64'(bus.pix_x), 64'd11);
      chk($sformatf("bp_hold%0d_valid", c), 64'(bus.pix_valid), 64'd1);
      if (c == 3) bus.pix_ready = 1'b1;
      @(negedge clk);
    end
    pix("bp_p2", 12'd12, 32'h3_0000, 1'b0, 1'b0);
    pix("bp_p3", 12'd13, 32'h4_0000, 1'b0, 1'b1);
    chk("bp_hs", 64'(hs - h0), 64'd4);
    chk("bp_end_sready", 64'(bus.span_ready), 64'd1);

    // Zero-length descriptor.
    offer(12'd5, 12'd0, 32'h1234_0000, 40'h0);
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("zl%0d_valid", c), 64'(bus.pix_valid), 64'd0);
      chk($sformatf("zl%0d_sready", c), 64'(bus.span_ready), 64'd1);
      @(negedge clk);
    end

    // Second descriptor held during RUN is accepted at the first IDLE cycle.
    offer(12'd30, 12'd3, 32'h0, 40'h00_0100_0000);
    bus.span_valid = 1'b1;
    bus.span_x     = 12'd100;
    bus.span_len   = 12'd2;
    bus.span_init  = 32'h0005_0000;
    bus.span_grad  = 40'hFF_FF00_0000;
    pix("br_p0", 12'd30, 32'h0, 1'b0, 1'b0);
    pix("br_p1", 12'd31, 32'h1_0000, 1'b0, 1'b0);
    pix("br_p2", 12'd32, 32'h2_0000, 1'b0, 1'b1);
    chk("br_bubble_valid", 64'(bus.pix_valid), 64'd0);
    chk("br_bubble_sready", 64'(bus.span_ready), 64'd1);
    @(negedge clk);
    bus.span_valid = 1'b0;
    pix("br_b0", 12'd100, 32'h5_0000, 1'b0, 1'b0);
    pix("br_b1", 12'd101, 32'h4_0000, 1'b0, 1'b1);
    chk("br_end_valid", 64'(bus.pix_valid), 64'd0);

    // Reset after two pixels drops the span.
    offer(12'd10, 12'd4, 32'h0001_0000, 40'h00_0100_0000);
    pix("mr_p0", 12'd10, 32'h1_0000, 1'b0, 1'b0);
    pix("mr_p1", 12'd11, 32'h2_0000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_valid", 64'(bus.pix_valid), 64'd0);
    chk("mr_sready", 64'(bus.span_ready), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    run_vec(tbl[0], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
